magic_ctrl: RTL
===============

// Module: magic_ctrl
// PURPOSE
//  Parametrised magic-mode controller: NMI entry/exit sequencing for the service ROM plus a generic
//  byte-wide config register file with full readback. Sits between cpu_bus and the top level; the top
//  level slices cfg_q into machine/turbo/panning/etc. Adds over the previous generation: N trigger
//  sources with latched cause, NMI acknowledge timeout, readable config registers, write strobes.
// PARAMETERS
//  NTRIG        2          number of trigger inputs (1..8)
//  NREGS        16         number of 8-bit config registers (1..254), index = a_reg[15:8]
//  CFG_RESET    '0         NREGS*8-bit reset image, byte i = reset value of register i
//  CFG_PORT     8'hFF      low address byte of config I/O port
//  NMI_VEC      16'h0066   M1 fetch address acknowledging NMI
//  EXIT_ADDR    16'hF000   read of this address while mapped = leave magic mode
//  REENTER_ADDR 16'hF008   read of this address while mapped = unmap, remap on next M1
//  NMI_TIMEOUT  4095       clk28 cycles n_nmi may stay low without acknowledge
// PORTS
//  clk28         input   1            system clock
//  rst_n         input   1            async active-low reset
//  bus           modport cpu_bus      memreq, ioreq, rd, wr, m1, a_reg[15:0], d_reg[7:0]
//  n_int         input   1            current frame interrupt
//  n_int_next    input   1            next-cycle frame interrupt (falling edge = 1 then 0)
//  trig          input   NTRIG        level trigger requests (magic, pause, ...)
//  status_in     input   8            live status bits, readable at index 8'hFF
//  n_nmi         output  1            NMI to CPU, active low
//  magic_mode    output  1            magic session active
//  magic_map     output  1            service ROM/RAM mapped
//  cfg_q         output  NREGS*8      config register contents, register i at [8i+7:8i]
//  cfg_wr        output  NREGS        one-cycle pulse when register i is written
//  d_out         output  8            readback data
//  d_out_active  output  1            d_out drives the CPU data bus
// BEHAVIOUR
//  Reset: state=MAPPED, magic_mode=1, magic_map=1, n_nmi=1, cause=0, cfg_q=CFG_RESET, cfg_wr=0,
//   d_out_active=0, timeout counter=0 (boot enters the service ROM).
//  Frame strobe fs = n_int==1 && n_int_next==0. Triggers sampled only on fs.
//  FSM magic_state_t {IDLE, NMI_REQ, MAPPED, UNMAP_PEND, REENTER}:
//   IDLE: fs && |trig -> n_nmi=0, magic_mode=1, cause=trig, counter cleared, NMI_REQ.
//   NMI_REQ: m1&&memreq&&a_reg==NMI_VEC -> n_nmi=1, magic_map=1, MAPPED.
//     Counter reaches NMI_TIMEOUT first -> n_nmi=1, magic_mode=0, cause=0, IDLE. Ack wins on same cycle.
//   MAPPED: memreq&&rd&&a_reg==EXIT_ADDR -> UNMAP_PEND, reenter=0; a_reg==REENTER_ADDR -> reenter=1.
//   UNMAP_PEND: first cycle with !memreq -> magic_map=0; reenter ? REENTER : (magic_mode=0, cause=0, IDLE).
//   REENTER: next m1&&memreq (any address) -> magic_map=1, MAPPED.
//  Triggers outside IDLE are ignored (no cause update, no second NMI).
//  Config select cs = magic_map && ioreq && a_reg[7:0]==CFG_PORT; inactive when unmapped.
//  Write: first clk28 of cs&&wr (edge-detected) with idx<NREGS -> reg[idx]<=d_reg, cfg_wr[idx]=1 for one
//   cycle; idx>=NREGS writes ignored. Held wr does not re-pulse.
//  Read: registered, one cycle after cs&&rd: idx<NREGS -> reg[idx]; 8'hFE -> cause zero-extended;
//   8'hFF -> status_in; other idx -> d_out_active=0. d_out_active drops the cycle after rd/cs drop.
//  Reset mid-session returns to reset values immediately (async), no pending NMI survives.
// STRUCTURE
//  common package: magic_state_t, MAGIC_IDX_CAUSE=8'hFE, MAGIC_IDX_STATUS=8'hFF.
//  Sub-module magic_cfg_regs: register file, write edge-detect, cfg_wr strobes, readback mux.
//  FSM, timeout counter and cause latch stay in magic_ctrl.
// TESTING
//  Release reset, read port 16'h02FF -> d_out_active next cycle, d_out=CFG_RESET byte 2.
//  Read 16'hF000 while mapped, drop memreq -> magic_map=0, magic_mode=0; trig=2'b01 at fs -> n_nmi=0,
//   M1 fetch 16'h0066 -> n_nmi=1, magic_map=1; read 16'hFEFF -> d_out=8'h01.
//  Trigger, withhold 16'h0066 fetch for NMI_TIMEOUT cycles -> n_nmi=1, magic_mode=0, state IDLE.
//  Mapped, read 16'hF008, !memreq -> magic_map=0, magic_mode=1; next M1 at 16'h1234 -> magic_map=1.
//  Write 8'hA5 to 16'h03FF with wr held 4 cycles -> cfg_q[31:24]=8'hA5, cfg_wr[3] high exactly 1 cycle;
//   write 16'h20FF (NREGS=16) -> no cfg_q change; same write while unmapped -> ignored.
//  Assert rst_n low during NMI_REQ -> n_nmi=1, magic_map=1, cfg_q=CFG_RESET without clock edge.

Source files
------------

// File: rtl/magic_ctrl_pkg.sv
// Shared types and constants for the magic-mode controller.
package magic_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        NMI_REQ,
        MAPPED,
        UNMAP_PEND,
        REENTER
    } magic_state_t;

    localparam logic [BYTE_W-1:0] MAGIC_IDX_CAUSE  = 8'hFE;
    localparam logic [BYTE_W-1:0] MAGIC_IDX_STATUS = 8'hFF;

endpackage

// File: rtl/cpu_bus.sv
// CPU bus as seen by the peripherals: strobes, registered address and data.
interface cpu_bus;
    logic        memreq;
    logic        ioreq;
    logic        rd;
    logic        wr;
    logic        m1;
    logic [15:0] a_reg;
    logic [7:0]  d_reg;

    modport ctrl (input memreq, ioreq, rd, wr, m1, a_reg, d_reg);
    modport cpu  (output memreq, ioreq, rd, wr, m1, a_reg, d_reg);
endinterface

// File: rtl/magic_cfg_regs.sv
// Byte-wide config register file: edge-detected writes with strobes, registered readback.
module magic_cfg_regs
    import magic_ctrl_pkg::*;
#(
    parameter int unsigned          NREGS     = 16,
    parameter logic [NREGS*8-1:0]   CFG_RESET = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [BYTE_W-1:0]    idx,
    input  logic [BYTE_W-1:0]    d_in,
    input  logic [BYTE_W-1:0]    cause,
    input  logic [BYTE_W-1:0]    status_in,
    output logic [NREGS*8-1:0]   cfg_q,
    output logic [NREGS-1:0]     cfg_wr,
    output logic [BYTE_W-1:0]    d_out,
    output logic                 d_out_active
);

    logic              wr_q;
    logic              wr_new_c;
    logic              rd_hit_c;
    logic [BYTE_W-1:0] rd_data_c;

    // Only the first cycle of a held write commits.
    assign wr_new_c = cs && wr && !wr_q;

    always_comb begin
        rd_hit_c  = 1'b0;
        rd_data_c = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (idx == 8'(i)) begin
                rd_hit_c  = 1'b1;
                rd_data_c = cfg_q[8*i +: 8];
            end
        end
        if (idx == MAGIC_IDX_CAUSE) begin
            rd_hit_c  = 1'b1;
            rd_data_c = cause;
        end else if (idx == MAGIC_IDX_STATUS) begin
            rd_hit_c  = 1'b1;
            rd_data_c = status_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q         <= 1'b0;
            cfg_q        <= CFG_RESET;
            cfg_wr       <= '0;
            d_out        <= '0;
            d_out_active <= 1'b0;
        end else begin
            wr_q   <= cs && wr;
            cfg_wr <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_new_c && idx == 8'(i)) begin
                    cfg_q[8*i +: 8] <= d_in;
                    cfg_wr[i]       <= 1'b1;
                end
            end
            d_out_active <= cs && rd && rd_hit_c;
            d_out        <= (cs && rd && rd_hit_c) ? rd_data_c : '0;
        end
    end

endmodule

// File: rtl/magic_ctrl.sv
// Magic-mode controller: NMI entry/exit sequencing for the service ROM plus config register file.
module magic_ctrl
    import magic_ctrl_pkg::*;
#(
    parameter int unsigned        NTRIG        = 2,
    parameter int unsigned        NREGS        = 16,
    parameter logic [NREGS*8-1:0] CFG_RESET    = '0,
    parameter logic [7:0]         CFG_PORT     = 8'hFF,
    parameter logic [15:0]        NMI_VEC      = 16'h0066,
    parameter logic [15:0]        EXIT_ADDR    = 16'hF000,
    parameter logic [15:0]        REENTER_ADDR = 16'hF008,
    parameter int unsigned        NMI_TIMEOUT  = 4095
) (
    input  logic                 clk28,
    input  logic                 rst_n,
    cpu_bus.ctrl                 bus,
    input  logic                 n_int,
    input  logic                 n_int_next,
    input  logic [NTRIG-1:0]     trig,
    input  logic [7:0]           status_in,
    output logic                 n_nmi,
    output logic                 magic_mode,
    output logic                 magic_map,
    output logic [NREGS*8-1:0]   cfg_q,
    output logic [NREGS-1:0]     cfg_wr,
    output logic [7:0]           d_out,
    output logic                 d_out_active
);

    localparam int unsigned CNT_W = $clog2(NMI_TIMEOUT + 1);

    magic_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [NTRIG-1:0] cause;
    logic             reenter;

    logic fs_c;
    logic ack_c;
    logic cs_c;

    assign fs_c  = n_int && !n_int_next;
    assign ack_c = bus.m1 && bus.memreq && (bus.a_reg == NMI_VEC);
    // Config port is only decoded while the service ROM is mapped.
    assign cs_c  = magic_map && bus.ioreq && (bus.a_reg[7:0] == CFG_PORT);

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MAPPED;
            magic_mode <= 1'b1;
            magic_map  <= 1'b1;
            n_nmi      <= 1'b1;
            cause      <= '0;
            cnt        <= '0;
            reenter    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fs_c && |trig) begin
                        n_nmi      <= 1'b0;
                        magic_mode <= 1'b1;
                        cause      <= trig;
                        cnt        <= '0;
                        state      <= NMI_REQ;
                    end
                end
                NMI_REQ: begin
                    // Acknowledge takes priority over a simultaneous timeout.
                    if (ack_c) begin
                        n_nmi     <= 1'b1;
                        magic_map <= 1'b1;
                        state     <= MAPPED;
                    end else if (cnt == CNT_W'(NMI_TIMEOUT - 1)) begin
                        n_nmi      <= 1'b1;
                        magic_mode <= 1'b0;
                        cause      <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MAPPED: begin
                    if (bus.memreq && bus.rd) begin
                        if (bus.a_reg == EXIT_ADDR) begin
                            reenter <= 1'b0;
                            state   <= UNMAP_PEND;
                        end else if (bus.a_reg == REENTER_ADDR) begin
                            reenter <= 1'b1;
                            state   <= UNMAP_PEND;
                        end
                    end
                end
                UNMAP_PEND: begin
                    // Wait for the exit read bus cycle to finish before unmapping.
                    if (!bus.memreq) begin
                        magic_map <= 1'b0;
                        if (reenter) begin
                            state <= REENTER;
                        end else begin
                            magic_mode <= 1'b0;
                            cause      <= '0;
                            state      <= IDLE;
                        end
                    end
                end
                REENTER: begin
                    if (bus.m1 && bus.memreq) begin
                        magic_map <= 1'b1;
                        state     <= MAPPED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    magic_cfg_regs #(
        .NREGS     (NREGS),
        .CFG_RESET (CFG_RESET)
    ) u_cfg_regs (
        .clk          (clk28),
        .rst_n        (rst_n),
        .cs           (cs_c),
        .wr           (bus.wr),
        .rd           (bus.rd),
        .idx          (bus.a_reg[15:8]),
        .d_in         (bus.d_reg),
        .cause        (8'(cause)),
        .status_in    (status_in),
        .cfg_q        (cfg_q),
        .cfg_wr       (cfg_wr),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

endmodule
